// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for the 4-neuron Maxnet datapath.
// Loads activations, alternates check/update until one neuron is left or the cap is hit.
module maxnet_controller #(
    parameter int MAX_ITER = 31,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             single_left,
    input  logic [3:0]       nz,
    output logic             ld_en,
    output logic             sel_init,
    output logic             upd_en,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             winner_valid,
    output logic [1:0]       winner_idx,
    output logic [CNT_W-1:0] iter_count
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, UPDATE, DONE} state_t;
    state_t r_state;
    logic w_one_hot;
    logic [1:0] w_idx;
    assign w_one_hot = (nz != 4'd0) && ((nz & (nz - 4'd1)) == 4'd0);
    assign w_idx = nz[3] ? 2'd3 : nz[2] ? 2'd2 : nz[1] ? 2'd1 : 2'd0;
    // Strobes are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            ld_en        <= 1'b0;
            sel_init     <= 1'b0;
            upd_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            winner_valid <= 1'b0;
            winner_idx   <= 2'd0;
            iter_count   <= '0;
        end else begin
            ld_en    <= 1'b0;
            sel_init <= 1'b0;
            upd_en   <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= LOAD;
                        ld_en        <= 1'b1;
                        sel_init     <= 1'b1;
                        iter_count   <= '0;
                        timeout      <= 1'b0;
                        winner_valid <= 1'b0;
                        winner_idx   <= 2'd0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: r_state <= CHECK;
                CHECK: begin
                    if (single_left) begin
                        r_state      <= DONE;
                        done         <= 1'b1;
                        winner_valid <= w_one_hot;
                        winner_idx   <= w_one_hot ? w_idx : 2'd0;
                    end else if (iter_count == CNT_W'(MAX_ITER)) begin
                        r_state      <= DONE;
                        done         <= 1'b1;
                        timeout      <= 1'b1;
                        winner_valid <= 1'b0;
                    end else begin
                        r_state <= UPDATE;
                        upd_en  <= 1'b1;
                    end
                end
                UPDATE: begin
                    r_state    <= CHECK;
                    iter_count <= iter_count + CNT_W'(1);
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maxnet_controller.sv
// tb_maxnet_controller: table-driven and randomized checks against a cycle-timeline model.
module tb_maxnet_controller;
    localparam int MAX = 4;
    localparam int CW  = 3;
    logic clk = 1'b0;
    logic rst, start, single_left;
    logic [3:0] nz;
    logic ld_en, sel_init, upd_en, busy, done, timeout, winner_valid;
    logic [1:0] winner_idx;
    logic [CW-1:0] iter_count;
    int checks = 0;
    int errors = 0;
    typedef struct {
        int         term;
        logic [3:0] nzv;
        int         k;
        logic       to;
        logic       wv;
        logic [1:0] idx;
    } vec_t;
    vec_t tbl[6];

    maxnet_controller #(.MAX_ITER(MAX), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .single_left(single_left), .nz(nz),
        .ld_en(ld_en), .sel_init(sel_init), .upd_en(upd_en), .busy(busy), .done(done),
        .timeout(timeout), .winner_valid(winner_valid), .winner_idx(winner_idx),
        .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {ld_en, sel_init, upd_en, busy, done, timeout, winner_valid, winner_idx, iter_count};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: run terminates at check number term (single_left=1 there), or at check MAX via cap.
    task automatic run(input int term, input logic [3:0] nzv);
        int k, nd, ec;
        logic to, wv, fin;
        logic [1:0] idx;
        to = term > MAX;
        k = to ? MAX : term;
        wv = !to && ($countones(nzv) == 1);
        idx = 2'd0;
        if (wv) for (int i = 0; i < 4; i++) if (nzv[i]) idx = 2'(i);
        nd = 3 + 2 * k;
        start = 1'b1;
        single_left = 1'($urandom);
        nz = 4'($urandom);
        for (int n = 1; n <= nd + 1; n++) begin
            @(negedge clk);
            ec = (n < 2) ? 0 : (((n - 2) / 2 < k) ? (n - 2) / 2 : k);
            fin = n >= nd;
            chk($sformatf("run_t%0d_cyc%0d", term, n), outs(),
                {n == 1, n == 1, (n % 2 == 1) && n >= 3 && n < nd, n <= nd, n == nd,
                 fin && to, fin && wv, fin ? idx : 2'd0, CW'(ec)});
            if (n % 2 == 0 && n < nd) begin
                single_left = ((n - 2) / 2 == term);
                nz = ((n - 2) / 2 == term) ? nzv : 4'($urandom);
            end else begin
                single_left = 1'($urandom);
                nz = 4'($urandom);
            end
            start = (n <= nd) ? 1'($urandom) : 1'b0;
        end
    endtask

    initial begin
        tbl[0] = '{term: 0, nzv: 4'b0100, k: 0, to: 1'b0, wv: 1'b1, idx: 2'd2};
        tbl[1] = '{term: 3, nzv: 4'b0001, k: 3, to: 1'b0, wv: 1'b1, idx: 2'd0};
        tbl[2] = '{term: 0, nzv: 4'b0000, k: 0, to: 1'b0, wv: 1'b0, idx: 2'd0};
        tbl[3] = '{term: 9, nzv: 4'b1111, k: 4, to: 1'b1, wv: 1'b0, idx: 2'd0};
        tbl[4] = '{term: 4, nzv: 4'b1000, k: 4, to: 1'b0, wv: 1'b1, idx: 2'd3};
        tbl[5] = '{term: 2, nzv: 4'b0110, k: 2, to: 1'b0, wv: 1'b0, idx: 2'd0};
        rst = 1'b1;
        start = 1'b0;
        single_left = 1'b0;
        nz = 4'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", outs(), 12'd0);
        rst = 1'b0;
        start = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            start = 1'b0;
            single_left = 1'b0;
        end
        chk("mid_update", outs(), {3'b001, 1'b1, 8'd0});
        rst = 1'b1;
        #1 chk("rst_async_clear", outs(), 12'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            chk($sformatf("post_rst_idle%0d", n), outs(), 12'd0);
        end
        for (int i = 0; i < 6; i++) begin
            run(tbl[i].term, tbl[i].nzv);
            chk($sformatf("tbl%0d_result", i),
                {5'd0, iter_count, timeout, winner_valid, winner_idx},
                {5'd0, CW'(tbl[i].k), tbl[i].to, tbl[i].wv, tbl[i].idx});
        end
        for (int i = 0; i < 20; i++) run(int'($urandom_range(0, 6)), 4'($urandom));
        start = 1'b0;
        @(negedge clk);
        chk("final_idle_busy", {11'd0, busy}, 12'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
